moving_avg_filter: RTL

MOVING_AVG_FILTER -- requirements
Module: moving_avg_filter

---
 rtl/mavg_pkg.sv | 19 +
 rtl/mavg_ring_buf.sv | 31 +++
 rtl/moving_avg_filter.sv | 106 ++++++++++
 3 files changed

// File: rtl/mavg_pkg.sv
// Shared constants and helpers for the moving-average filter.
package mavg_pkg;

  localparam int LOG2_WIN_MIN   = 1;
  localparam int LOG2_WIN_MAX   = 10;
  localparam int DATA_WIDTH_MIN = 2;
  localparam int DATA_WIDTH_MAX = 32;

  // Accumulator width: the sum of WIN samples grows by LOG2_WIN bits.
  function automatic int acc_width(input int data_width, input int log2_win);
    return data_width + log2_win;
  endfunction

  // Half an LSB of the output, added before the divide-by-shift.
  function automatic int round_const(input int log2_win);
    return 1 << (log2_win - 1);
  endfunction

endpackage

// File: rtl/mavg_ring_buf.sv
// Window storage: WIN x DATA_WIDTH ring with wrapping write pointer and
// combinational read of the entry about to be overwritten.
module mavg_ring_buf #(
  parameter int DATA_WIDTH = 24,
  parameter int LOG2_WIN   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [1 << LOG2_WIN];
  logic [LOG2_WIN-1:0]   wp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wp <= '0;
    else if (clr)    wp <= '0;
    else if (we)     wp <= wp + 1'b1;
  end

  // Storage is deliberately unreset; stale entries are masked by the fill logic.
  always_ff @(posedge clk) begin
    if (we && !clr) mem[wp] <= wdata;
  end

  assign rdata = mem[wp];

endmodule

// File: rtl/moving_avg_filter.sv
// Running mean over the last 2**LOG2_WIN samples, round-half-up, 2-cycle latency,
// one sample per cycle, no backpressure.
module moving_avg_filter #(
  parameter int DATA_WIDTH  = 24,
  parameter int LOG2_WIN    = 4,
  parameter int SIGNED_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  win_full
);
  import mavg_pkg::*;

  localparam int               WIN     = 1 << LOG2_WIN;
  localparam int               ACC_W   = acc_width(DATA_WIDTH, LOG2_WIN);
  localparam logic [LOG2_WIN:0] WIN_CNT = (LOG2_WIN + 1)'(WIN);
  localparam logic [ACC_W:0]   RND     = (ACC_W + 1)'(round_const(LOG2_WIN));

  if (LOG2_WIN < LOG2_WIN_MIN || LOG2_WIN > LOG2_WIN_MAX ||
      DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX ||
      (SIGNED_MODE != 0 && SIGNED_MODE != 1)) begin : g_param_check
    $error("moving_avg_filter: illegal parameter value");
  end

  logic                  accept;
  logic [DATA_WIDTH-1:0] old_dat;
  logic [ACC_W-1:0]      acc, acc_next, in_ext, old_ext;
  logic [LOG2_WIN:0]     fill, fill_next;
  logic                  s1_vld;

  // clr has priority: a coincident sample is dropped.
  assign accept = in_valid && !clr;

  mavg_ring_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2_WIN   (LOG2_WIN)
  ) u_ring_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .we    (accept),
    .wdata (in_data),
    .rdata (old_dat)
  );

  always_comb begin
    in_ext  = '0;
    old_ext = '0;
    if (SIGNED_MODE != 0) begin
      in_ext  = {{LOG2_WIN{in_data[DATA_WIDTH-1]}}, in_data};
      old_ext = {{LOG2_WIN{old_dat[DATA_WIDTH-1]}}, old_dat};
    end else begin
      in_ext  = {{LOG2_WIN{1'b0}}, in_data};
      old_ext = {{LOG2_WIN{1'b0}}, old_dat};
    end
    // Until the window is full the evicted slot holds nothing valid.
    if (!win_full) old_ext = '0;
    acc_next  = acc + in_ext - old_ext;
    fill_next = (fill == WIN_CNT) ? fill : fill + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      fill     <= '0;
      win_full <= 1'b0;
      s1_vld   <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      fill     <= '0;
      win_full <= 1'b0;
      s1_vld   <= 1'b0;
    end else if (in_valid) begin
      acc      <= acc_next;
      fill     <= fill_next;
      win_full <= (fill_next == WIN_CNT);
      s1_vld   <= (fill_next == WIN_CNT);
    end else begin
      s1_vld   <= 1'b0;
    end
  end

  // Stage 2: round and divide; the extra sum bit keeps the rounding add exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        if (SIGNED_MODE != 0)
          out_data <= DATA_WIDTH'($signed({acc[ACC_W-1], acc} + RND) >>> LOG2_WIN);
        else
          out_data <= DATA_WIDTH'(({1'b0, acc} + RND) >> LOG2_WIN);
      end
    end
  end

endmodule
